// File: rtl/pwm_thres_ctrl.sv
// Double-buffered threshold bank for the multiplexed PWM engine.
// The host fills a staged bank; a commit copies it into the active bank at the next period boundary.
module pwm_thres_ctrl #(
    parameter int pwm_width = 16,
    parameter int num_pwm   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(num_pwm)-1:0] wr_id,
    input  logic [pwm_width-1:0]       wr_data,
    input  logic                       commit,
    output logic                       busy,
    output logic                       commit_done,
    output logic                       wr_err,
    input  logic [$clog2(num_pwm)-1:0] thres_id,
    output logic [pwm_width-1:0]       thres,
    input  logic                       latch_mem
);

    localparam int IDW   = $clog2(num_pwm);
    localparam int NSLOT = 1 << IDW;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [pwm_width-1:0]   staged_q [NSLOT];
    logic [pwm_width-1:0]   active_q [NSLOT];
    logic [pwm_width-1:0]   thres_q, thres_d;
    logic                   commit_done_q, commit_done_d;
    logic                   wr_err_q, wr_err_d;
    logic [NSLOT-1:0]       idOk;
    logic                   wrAccept;
    logic                   apply;

    // Index slots beyond num_pwm exist only when num_pwm is not a power of two; they are never written and always read as 0.
    for (genvar g = 0; g < NSLOT; g++) begin : g_id_ok
        assign idOk[g] = (g < num_pwm);
    end

    assign wrAccept = wr_valid && wr_ready;
    assign apply    = (state_q == PENDING) && latch_mem;

    always_comb begin
        state_d       = state_q;
        wr_ready      = 1'b0;
        busy          = 1'b0;
        thres_d       = '0;
        commit_done_d = apply;
        wr_err_d      = wrAccept && !idOk[wr_id];

        case (state_q)
            IDLE: begin
                wr_ready = 1'b1;
                if (commit) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                busy = 1'b1;
                if (latch_mem) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // On the apply edge the staged value is forwarded so the first slot of the new period already sees it.
        if (idOk[thres_id]) begin
            thres_d = apply ? staged_q[thres_id] : active_q[thres_id];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            thres_q       <= '0;
            commit_done_q <= 1'b0;
            wr_err_q      <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                staged_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            thres_q       <= thres_d;
            commit_done_q <= commit_done_d;
            wr_err_q      <= wr_err_d;
            if (wrAccept && idOk[wr_id]) begin
                staged_q[wr_id] <= wr_data;
            end
            if (apply) begin
                for (int i = 0; i < NSLOT; i++) begin
                    active_q[i] <= staged_q[i];
                end
            end
        end
    end

    assign thres       = thres_q;
    assign commit_done = commit_done_q;
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_pwm_thres_ctrl.sv
// Bench for pwm_thres_ctrl: directed vector tables for a 4-channel and a 3-channel instance,
// followed by randomized traffic on the 4-channel instance checked against a bank-level model.
module tb_pwm_thres_ctrl;

   typedef struct {
      logic        rst;
      logic        wrValid;
      logic [1:0]  wrId;
      logic [15:0] wrData;
      logic        commit;
      logic        latch;
      logic [1:0]  tid;
      logic [15:0] eThres;
      logic        eReady;
      logic        eBusy;
      logic        eDone;
      logic        eErr;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: four channels
   logic        rstA = 1'b1, wrValidA = 1'b0, commitA = 1'b0, latchA = 1'b0;
   logic [1:0]  wrIdA = '0, tidA = '0;
   logic [15:0] wrDataA = '0;
   logic        wrReadyA, busyA, doneA, errA;
   logic [15:0] thresA;

   // Instance B: three channels, so id 3 is out of range
   logic        rstB = 1'b1, wrValidB = 1'b0, commitB = 1'b0, latchB = 1'b0;
   logic [1:0]  wrIdB = '0, tidB = '0;
   logic [15:0] wrDataB = '0;
   logic        wrReadyB, busyB, doneB, errB;
   logic [15:0] thresB;

   pwm_thres_ctrl #(.pwm_width(16), .num_pwm(4)) dutA (
      .clk(clk), .rst(rstA), .wr_valid(wrValidA), .wr_ready(wrReadyA),
      .wr_id(wrIdA), .wr_data(wrDataA), .commit(commitA), .busy(busyA),
      .commit_done(doneA), .wr_err(errA), .thres_id(tidA), .thres(thresA),
      .latch_mem(latchA)
   );

   pwm_thres_ctrl #(.pwm_width(16), .num_pwm(3)) dutB (
      .clk(clk), .rst(rstB), .wr_valid(wrValidB), .wr_ready(wrReadyB),
      .wr_id(wrIdB), .wr_data(wrDataB), .commit(commitB), .busy(busyB),
      .commit_done(doneB), .wr_err(errB), .thres_id(tidB), .thres(thresB),
      .latch_mem(latchB)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: two banks plus a pending flag, evaluated once per clock edge
   logic [15:0] mStaged [4];
   logic [15:0] mActive [4];
   bit          mPend;
   logic [15:0] mThres;
   bit          mDone, mErr;

   function automatic vec_t mk(input logic r, input logic v, input int id, input int d,
                               input logic c, input logic l, input int t, input int eT,
                               input logic eR, input logic eB, input logic eD, input logic eE);
      vec_t x;
      x.rst = r; x.wrValid = v; x.wrId = id[1:0]; x.wrData = d[15:0];
      x.commit = c; x.latch = l; x.tid = t[1:0]; x.eThres = eT[15:0];
      x.eReady = eR; x.eBusy = eB; x.eDone = eD; x.eErr = eE;
      return x;
   endfunction

   task automatic modelStep(input vec_t v, input int nch);
      bit apply, accept;
      if (v.rst) begin
         for (int i = 0; i < 4; i++) begin
            mStaged[i] = '0;
            mActive[i] = '0;
         end
         mPend = 0; mThres = '0; mDone = 0; mErr = 0;
      end else begin
         apply  = mPend && v.latch;
         accept = !mPend && v.wrValid;
         if (int'(v.tid) >= nch) mThres = '0;
         else mThres = apply ? mStaged[v.tid] : mActive[v.tid];
         mErr  = accept && (int'(v.wrId) >= nch);
         mDone = apply;
         if (apply) begin
            for (int i = 0; i < 4; i++) mActive[i] = mStaged[i];
         end
         if (accept && int'(v.wrId) < nch) mStaged[v.wrId] = v.wrData;
         if (apply) mPend = 0;
         else if (!mPend && v.commit) mPend = 1;
      end
   endtask

   task automatic applyStimulus(input int which, input vec_t v);
      if (which == 0) begin
         rstA = v.rst; wrValidA = v.wrValid; wrIdA = v.wrId; wrDataA = v.wrData;
         commitA = v.commit; latchA = v.latch; tidA = v.tid;
      end else begin
         rstB = v.rst; wrValidB = v.wrValid; wrIdB = v.wrId; wrDataB = v.wrData;
         commitB = v.commit; latchB = v.latch; tidB = v.tid;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] aT, input logic aR,
                              input logic aB, input logic aD, input logic aE,
                              input logic [15:0] eT, input logic eR, input logic eB,
                              input logic eD, input logic eE);
      checks++;
      if ({aT, aR, aB, aD, aE} !== {eT, eR, eB, eD, eE}) begin
         errors++;
         $display("[TB] FAIL %s: got thres=%h ready=%b busy=%b done=%b err=%b, expected thres=%h ready=%b busy=%b done=%b err=%b",
                  name, aT, aR, aB, aD, aE, eT, eR, eB, eD, eE);
      end
   endtask

   vec_t vecA[$];
   vec_t vecB[$];

   initial begin
      //                rst v  id  data     c  l  tid thres    rdy bsy dn er
      vecA.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0));
      for (int t = 0; t < 4; t++)
         vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 0, t, 16'h0000, 1, 0, 0, 0));
      vecA.push_back(mk(0, 1, 0, 16'h1000, 0, 0, 0, 16'h0000, 1, 0, 0, 0));
      vecA.push_back(mk(0, 1, 1, 16'h2000, 0, 0, 0, 16'h0000, 1, 0, 0, 0));
      vecA.push_back(mk(0, 1, 2, 16'h3000, 0, 0, 0, 16'h0000, 1, 0, 0, 0));
      vecA.push_back(mk(0, 1, 3, 16'hFFFF, 0, 0, 0, 16'h0000, 1, 0, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 3, 16'h0000, 1, 0, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 0));
      for (int k = 0; k < 4; k++)
         vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h1000, 1, 0, 1, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'h2000, 1, 0, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 2, 16'h3000, 1, 0, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 3, 16'hFFFF, 1, 0, 0, 0));
      vecA.push_back(mk(0, 1, 2, 16'h0ABC, 1, 1, 2, 16'h3000, 0, 1, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 2, 16'h3000, 0, 1, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 2, 16'h0ABC, 1, 0, 1, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 2, 16'h0ABC, 1, 0, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h1000, 1, 0, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h1000, 0, 1, 0, 0));
      vecA.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 2, 16'h0000, 1, 0, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 3, 16'h0000, 1, 0, 1, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000, 0, 1, 0, 0));
      vecA.push_back(mk(0, 1, 1, 16'h7777, 0, 0, 1, 16'h0000, 0, 1, 0, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 1, 16'h0000, 1, 0, 1, 0));
      vecA.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 0, 0));

      vecB.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0));
      vecB.push_back(mk(0, 1, 0, 16'h1111, 0, 0, 0, 16'h0000, 1, 0, 0, 0));
      vecB.push_back(mk(0, 1, 3, 16'h5555, 0, 0, 0, 16'h0000, 1, 0, 0, 1));
      vecB.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0));
      vecB.push_back(mk(0, 1, 3, 16'hAAAA, 0, 0, 0, 16'h0000, 1, 0, 0, 1));
      vecB.push_back(mk(0, 1, 3, 16'h5555, 0, 0, 0, 16'h0000, 1, 0, 0, 1));
      vecB.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0));
      vecB.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 0));
      vecB.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 3, 16'h0000, 1, 0, 1, 0));
      vecB.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h1111, 1, 0, 0, 0));
      vecB.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 0, 0));
      vecB.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 2, 16'h0000, 1, 0, 0, 0));
      vecB.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 3, 16'h0000, 1, 0, 0, 0));
      vecB.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h1111, 0, 1, 0, 0));
      vecB.push_back(mk(0, 1, 3, 16'h5555, 0, 0, 0, 16'h1111, 0, 1, 0, 0));
      vecB.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h1111, 1, 0, 1, 0));

      // Directed tables
      foreach (vecA[i]) begin
         applyStimulus(0, vecA[i]);
         checkOutput($sformatf("A_vec%0d", i), thresA, wrReadyA, busyA, doneA, errA,
                     vecA[i].eThres, vecA[i].eReady, vecA[i].eBusy, vecA[i].eDone, vecA[i].eErr);
      end
      foreach (vecB[i]) begin
         applyStimulus(1, vecB[i]);
         checkOutput($sformatf("B_vec%0d", i), thresB, wrReadyB, busyB, doneB, errB,
                     vecB[i].eThres, vecB[i].eReady, vecB[i].eBusy, vecB[i].eDone, vecB[i].eErr);
      end

      // Randomized traffic on instance A; the first cycle is a reset to align the model
      for (int n = 0; n < 600; n++) begin
         vec_t v;
         v.rst     = (n == 0) || ($urandom_range(0, 79) == 0);
         v.wrValid = $urandom_range(0, 1) == 1;
         v.wrId    = 2'($urandom_range(0, 3));
         v.wrData  = 16'($urandom);
         v.commit  = $urandom_range(0, 7) == 0;
         v.latch   = $urandom_range(0, 5) == 0;
         v.tid     = 2'($urandom_range(0, 3));
         applyStimulus(0, v);
         modelStep(v, 4);
         checkOutput($sformatf("A_rand%0d", n), thresA, wrReadyA, busyA, doneA, errA,
                     mThres, !mPend, mPend, mDone, mErr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
